crab_core: RTL and testbench

Multi-cycle RV32I integer core with a single shared instruction/data memory bus. Fetches, decodes and executes one instruction at a time through a small state machine; all memory traffic uses a valid/ready request bus toward an external memory model or bus bridge. Debug outputs expose the register file, PC and state for testbench inspection.

---
 rtl/crab_core.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_crab_core.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crab_core.sv
// crab_core: multi-cycle RV32I core sharing one valid/ready bus for fetches, loads and stores.
// Define CRABCORE_DEBUG_EN to drive registers_debug, pc_debug and core_state_debug; otherwise they read 0.
module crab_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_addr_valid,
    output logic [31:0] mem_addr,
    output logic        mem_data_valid,
    output logic [31:0] mem_data,
    input  logic        mem_ready,
    input  logic [31:0] mem_input,
    output logic [1:0]  io_mode,
    output logic [31:0] registers_debug [32],
    output logic [31:0] pc_debug,
    output logic [3:0]  core_state_debug
);

    localparam logic [3:0] ST_FETCH      = 4'd0;
    localparam logic [3:0] ST_FETCH_WAIT = 4'd1;
    localparam logic [3:0] ST_EXECUTE    = 4'd2;
    localparam logic [3:0] ST_LOAD_WAIT  = 4'd3;
    localparam logic [3:0] ST_STORE      = 4'd4;
    localparam logic [3:0] ST_HALT       = 4'd5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    logic [3:0]  state;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] regs [32];

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode  = instr[6:0];
    assign rd      = instr[11:7];
    assign funct3  = instr[14:12];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    // x0 is never written, so its reset value of 0 is what every read sees.
    assign rs1_val = regs[rs1];
    assign rs2_val = regs[rs2];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    logic [31:0] alu_b;
    logic [4:0]  shamt;
    logic [31:0] alu_result;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        alu_b = (opcode == OPC_OP) ? rs2_val : imm_i;
        shamt = alu_b[4:0];
        case (funct3)
            3'b000:  alu_result = (opcode == OPC_OP && instr[30]) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001:  alu_result = rs1_val << shamt;
            3'b010:  alu_result = {31'b0, $signed(rs1_val) < $signed(alu_b)};
            3'b011:  alu_result = {31'b0, rs1_val < alu_b};
            3'b100:  alu_result = rs1_val ^ alu_b;
            3'b101:  alu_result = instr[30] ? $unsigned($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
            3'b110:  alu_result = rs1_val | alu_b;
            default: alu_result = rs1_val & alu_b;
        endcase
    end

    logic branch_taken;

    always_comb begin
        case (funct3)
            3'b000:  branch_taken = rs1_val == rs2_val;
            3'b001:  branch_taken = rs1_val != rs2_val;
            3'b100:  branch_taken = $signed(rs1_val) < $signed(rs2_val);
            3'b101:  branch_taken = $signed(rs1_val) >= $signed(rs2_val);
            3'b110:  branch_taken = rs1_val < rs2_val;
            3'b111:  branch_taken = rs1_val >= rs2_val;
            default: branch_taken = 1'b0;
        endcase
    end

    logic        exec_wb_en;
    logic [31:0] exec_wb_data;
    logic [31:0] exec_next_pc;
    logic        exec_halt;
    logic        exec_load;
    logic        exec_store;

    always_comb begin
        exec_wb_en   = 1'b0;
        exec_wb_data = alu_result;
        exec_next_pc = pc + 32'd4;
        exec_halt    = 1'b0;
        exec_load    = 1'b0;
        exec_store   = 1'b0;
        case (opcode)
            OPC_LUI: begin
                exec_wb_en   = 1'b1;
                exec_wb_data = imm_u;
            end
            OPC_AUIPC: begin
                exec_wb_en   = 1'b1;
                exec_wb_data = pc + imm_u;
            end
            OPC_JAL: begin
                exec_wb_en   = 1'b1;
                exec_wb_data = pc + 32'd4;
                exec_next_pc = pc + imm_j;
            end
            OPC_JALR: begin
                exec_wb_en   = 1'b1;
                exec_wb_data = pc + 32'd4;
                exec_next_pc = (rs1_val + imm_i) & 32'hFFFF_FFFE;
            end
            OPC_BRANCH: if (branch_taken) exec_next_pc = pc + imm_b;
            OPC_LOAD:   exec_load  = 1'b1;
            OPC_STORE:  exec_store = 1'b1;
            OPC_IMM, OPC_OP: exec_wb_en = 1'b1;
            OPC_FENCE:  exec_wb_en = 1'b0;
            default: begin
                // ECALL, EBREAK and unknown opcodes stop the core with PC left on the instruction.
                exec_halt    = 1'b1;
                exec_next_pc = pc;
            end
        endcase
    end

    logic [1:0]  ls_mode;
    logic [31:0] store_data;

    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                ls_mode    = 2'd2;
                store_data = {24'b0, rs2_val[7:0]};
            end
            2'b01: begin
                ls_mode    = 2'd1;
                store_data = {16'b0, rs2_val[15:0]};
            end
            default: begin
                ls_mode    = 2'd0;
                store_data = rs2_val;
            end
        endcase
    end

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    // mem_addr still holds the load address during LOAD_WAIT, so it steers the lane select.
    always_comb begin
        case (mem_addr[1:0])
            2'd0:    load_byte = mem_input[7:0];
            2'd1:    load_byte = mem_input[15:8];
            2'd2:    load_byte = mem_input[23:16];
            default: load_byte = mem_input[31:24];
        endcase
        load_half = mem_addr[1] ? mem_input[31:16] : mem_input[15:0];
        case (funct3)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b100:  load_data = {24'b0, load_byte};
            3'b101:  load_data = {16'b0, load_half};
            default: load_data = mem_input;
        endcase
    end

    logic        rf_we;
    logic [31:0] rf_wdata;

    always_comb begin
        rf_we    = 1'b0;
        rf_wdata = exec_wb_data;
        if (state == ST_EXECUTE) begin
            rf_we = exec_wb_en;
        end else if (state == ST_LOAD_WAIT && mem_ready) begin
            rf_we    = 1'b1;
            rf_wdata = load_data;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the register file is cleared on reset because its contents are architecturally visible.
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (rf_we && rd != 5'd0) begin
            regs[rd] <= rf_wdata;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state          <= ST_FETCH;
            pc             <= RESET_PC;
            instr          <= '0;
            mem_addr_valid <= 1'b0;
            mem_addr       <= '0;
            mem_data_valid <= 1'b0;
            mem_data       <= '0;
            io_mode        <= 2'd0;
        end else begin
            case (state)
                ST_FETCH: begin
                    mem_addr_valid <= 1'b1;
                    mem_data_valid <= 1'b0;
                    mem_addr       <= pc;
                    io_mode        <= 2'd0;
                    state          <= ST_FETCH_WAIT;
                end
                ST_FETCH_WAIT: if (mem_ready) begin
                    instr          <= mem_input;
                    mem_addr_valid <= 1'b0;
                    state          <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    pc <= exec_next_pc;
                    if (exec_halt) begin
                        state <= ST_HALT;
                    end else if (exec_load) begin
                        mem_addr_valid <= 1'b1;
                        mem_addr       <= rs1_val + imm_i;
                        io_mode        <= ls_mode;
                        state          <= ST_LOAD_WAIT;
                    end else if (exec_store) begin
                        mem_addr_valid <= 1'b1;
                        mem_data_valid <= 1'b1;
                        mem_addr       <= rs1_val + imm_s;
                        mem_data       <= store_data;
                        io_mode        <= ls_mode;
                        state          <= ST_STORE;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                ST_LOAD_WAIT: if (mem_ready) begin
                    mem_addr_valid <= 1'b0;
                    state          <= ST_FETCH;
                end
                ST_STORE: begin
                    mem_addr_valid <= 1'b0;
                    mem_data_valid <= 1'b0;
                    state          <= ST_FETCH;
                end
                default: state <= ST_HALT;
            endcase
        end
    end

`ifdef CRABCORE_DEBUG_EN
    always_comb begin
        for (int i = 0; i < 32; i++) registers_debug[i] = regs[i];
    end
    assign pc_debug         = pc;
    assign core_state_debug = state;
`else
    always_comb begin
        for (int i = 0; i < 32; i++) registers_debug[i] = '0;
    end
    assign pc_debug         = '0;
    assign core_state_debug = '0;
`endif

endmodule

// File: tb/tb_crab_core.sv
// tb_crab_core: directed bench running hand-assembled RV32I programs on crab_core.
// A one-cycle-latency memory model answers reads and logs every request it sees.
module tb_crab_core;

    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [31:0] ECALL    = 32'h0000_0073;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_addr_valid;
    logic [31:0] mem_addr;
    logic        mem_data_valid;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [31:0] mem_input;
    logic [1:0]  io_mode;
    logic [31:0] registers_debug [32];
    logic [31:0] pc_debug;
    logic [3:0]  core_state_debug;

    crab_core dut (
        .clk              (clk),
        .reset            (reset),
        .mem_addr_valid   (mem_addr_valid),
        .mem_addr         (mem_addr),
        .mem_data_valid   (mem_data_valid),
        .mem_data         (mem_data),
        .mem_ready        (mem_ready),
        .mem_input        (mem_input),
        .io_mode          (io_mode),
        .registers_debug  (registers_debug),
        .pc_debug         (pc_debug),
        .core_state_debug (core_state_debug)
    );

    always #5 clk = ~clk;

    logic [31:0] img [256];
    logic [31:0] mem [256];
    int          load_gen;
    logic        stall;

    logic [31:0] rd_addr [128];
    logic [1:0]  rd_mode [128];
    int          rd_cyc  [128];
    int          rd_n;
    logic [31:0] st_addr [64];
    logic [31:0] st_data [64];
    logic [1:0]  st_mode [64];
    int          st_n;

    int checks;
    int errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    // Memory model: sole writer of mem, reports read data one cycle after a request appears.
    initial begin
        int seen_gen;
        logic prev_valid;
        int cyc;
        seen_gen   = 0;
        prev_valid = 1'b0;
        cyc        = 0;
        rd_n       = 0;
        st_n       = 0;
        mem_ready  = 1'b0;
        mem_input  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (seen_gen != load_gen) begin
                for (int i = 0; i < 256; i++) mem[i] = img[i];
                seen_gen = load_gen;
            end
            if (mem_addr_valid === 1'b1 && !prev_valid) begin
                if (mem_data_valid === 1'b1) begin
                    if (st_n < 64) begin
                        st_addr[st_n] = mem_addr;
                        st_data[st_n] = mem_data;
                        st_mode[st_n] = io_mode;
                    end
                    st_n++;
                    case (io_mode)
                        2'd2:    mem[mem_addr[9:2]][8*mem_addr[1:0] +: 8] = mem_data[7:0];
                        2'd1:    mem[mem_addr[9:2]][16*mem_addr[1] +: 16] = mem_data[15:0];
                        default: mem[mem_addr[9:2]] = mem_data;
                    endcase
                end else begin
                    if (rd_n < 128) begin
                        rd_addr[rd_n] = mem_addr;
                        rd_mode[rd_n] = io_mode;
                        rd_cyc[rd_n]  = cyc;
                    end
                    rd_n++;
                end
            end
            prev_valid = (mem_addr_valid === 1'b1);
            mem_ready  = (mem_addr_valid === 1'b1) && (mem_data_valid !== 1'b1) && !stall;
            mem_input  = mem[mem_addr[9:2]];
        end
    end

    initial begin
        logic [3:0] st_seq [4];
        int snap_rd;
        int snap_st;
        int base;
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        stall    = 1'b0;
        load_gen = 0;

        // Program A: ALU, branches, jumps, byte/half/word loads and stores, then ecall.
        for (int i = 0; i < 256; i++) img[i] = '0;
        img[0]  = enc_i(12'd5,    5'd0, 3'd0, 5'd1, OPC_IMM);   // addi x1,x0,5
        img[1]  = enc_s(12'h100,  5'd1, 5'd0, 3'd2);            // sw x1,0x100
        img[2]  = enc_i(12'hFFF,  5'd0, 3'd0, 5'd2, OPC_IMM);   // addi x2,x0,-1
        img[3]  = enc_s(12'd3,    5'd2, 5'd0, 3'd0);            // sb x2,3
        img[4]  = enc_i(12'd3,    5'd0, 3'd0, 5'd3, OPC_LOAD);  // lb x3,3
        img[5]  = enc_i(12'd3,    5'd0, 3'd4, 5'd4, OPC_LOAD);  // lbu x4,3
        img[6]  = enc_s(12'h104,  5'd3, 5'd0, 3'd2);
        img[7]  = enc_s(12'h108,  5'd4, 5'd0, 3'd2);
        img[8]  = enc_i(12'd7,    5'd0, 3'd0, 5'd0, OPC_IMM);   // addi x0,x0,7
        img[9]  = enc_s(12'h10C,  5'd0, 5'd0, 3'd2);
        img[10] = enc_i(12'd1,    5'd0, 3'd0, 5'd1, OPC_IMM);   // addi x1,x0,1
        img[11] = enc_b(13'd8,    5'd0, 5'd1, 3'd1);            // 44: bne x1,x0,+8
        img[12] = enc_i(12'h066,  5'd0, 3'd0, 5'd6, OPC_IMM);   // skipped
        img[13] = enc_j(21'd8,    5'd0);                        // 52: jal x0,+8
        img[14] = enc_j(21'd12,   5'd5);                        // 56: jal x5,+12
        img[15] = enc_j(21'h1FFFFC, 5'd7);                      // 60: jal x7,-4
        img[16] = enc_i(12'h077,  5'd0, 3'd0, 5'd6, OPC_IMM);   // skipped
        img[17] = enc_s(12'h110,  5'd5, 5'd0, 3'd2);
        img[18] = enc_s(12'h114,  5'd7, 5'd0, 3'd2);
        img[19] = enc_s(12'h118,  5'd6, 5'd0, 3'd2);
        img[20] = {20'h12345, 5'd8, OPC_LUI};                   // lui x8,0x12345
        img[21] = enc_i(12'hFF8,  5'd0, 3'd0, 5'd9, OPC_IMM);   // addi x9,x0,-8
        img[22] = enc_i(12'h401,  5'd9, 3'd5, 5'd10, OPC_IMM);  // srai x10,x9,1
        img[23] = enc_i(12'd28,   5'd9, 3'd5, 5'd11, OPC_IMM);  // srli x11,x9,28
        img[24] = enc_r(7'h00, 5'd1, 5'd9, 3'd2, 5'd12);        // slt x12,x9,x1
        img[25] = enc_r(7'h00, 5'd1, 5'd9, 3'd3, 5'd13);        // sltu x13,x9,x1
        img[26] = enc_r(7'h20, 5'd9, 5'd1, 3'd0, 5'd14);        // sub x14,x1,x9
        img[27] = enc_r(7'h00, 5'd9, 5'd8, 3'd0, 5'd15);        // add x15,x8,x9
        img[28] = {20'h00001, 5'd16, OPC_AUIPC};                // 112: auipc x16,1
        img[29] = enc_s(12'h120, 5'd8,  5'd0, 3'd2);
        img[30] = enc_s(12'h124, 5'd10, 5'd0, 3'd2);
        img[31] = enc_s(12'h128, 5'd11, 5'd0, 3'd2);
        img[32] = enc_s(12'h12C, 5'd12, 5'd0, 3'd2);
        img[33] = enc_s(12'h130, 5'd13, 5'd0, 3'd2);
        img[34] = enc_s(12'h134, 5'd14, 5'd0, 3'd2);
        img[35] = enc_s(12'h138, 5'd15, 5'd0, 3'd2);
        img[36] = enc_s(12'h13C, 5'd16, 5'd0, 3'd2);
        img[37] = enc_s(12'h142, 5'd9,  5'd0, 3'd1);            // sh x9,0x142
        img[38] = enc_i(12'h142, 5'd0, 3'd1, 5'd17, OPC_LOAD);  // lh x17,0x142
        img[39] = enc_i(12'h142, 5'd0, 3'd5, 5'd18, OPC_LOAD);  // lhu x18,0x142
        img[40] = enc_s(12'h144, 5'd17, 5'd0, 3'd2);
        img[41] = enc_s(12'h148, 5'd18, 5'd0, 3'd2);
        img[42] = enc_i(12'h100, 5'd0, 3'd2, 5'd19, OPC_LOAD);  // lw x19,0x100
        img[43] = enc_s(12'h14C, 5'd19, 5'd0, 3'd2);
        img[44] = ECALL;                                        // 176
        load_gen = 1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_addr_valid", {31'b0, mem_addr_valid}, 32'd0);
        check("reset_data_valid", {31'b0, mem_data_valid}, 32'd0);
        check("reset_addr", mem_addr, 32'd0);
        check("reset_data", mem_data, 32'd0);
        check("reset_io_mode", {30'b0, io_mode}, 32'd0);
        reset = 1'b0;
        st_seq[0] = core_state_debug;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            st_seq[i] = core_state_debug;
        end
`ifdef CRABCORE_DEBUG_EN
        check("state_seq0", {28'b0, st_seq[0]}, 32'd0);
        check("state_seq1", {28'b0, st_seq[1]}, 32'd1);
        check("state_seq2", {28'b0, st_seq[2]}, 32'd2);
        check("state_seq3", {28'b0, st_seq[3]}, 32'd0);
        check("first_pc", pc_debug, 32'd4);
        check("first_x1", registers_debug[1], 32'd5);
`else
        check("dbg_state_off", {28'b0, st_seq[2]}, 32'd0);
        check("dbg_pc_off", pc_debug, 32'd0);
`endif

        repeat (300) @(negedge clk);
        check("x1_addi", mem[64], 32'd5);
        check("sb_word", mem[0], 32'hFF50_0093);
        check("lb_sext", mem[65], 32'hFFFF_FFFF);
        check("lbu_zext", mem[66], 32'h0000_00FF);
        check("x0_const", mem[67], 32'd0);
        check("jal_link", mem[68], 32'd60);
        check("jal_back_link", mem[69], 32'd64);
        check("skipped_x6", mem[70], 32'd0);
        check("lui", mem[72], 32'h1234_5000);
        check("srai", mem[73], 32'hFFFF_FFFC);
        check("srli", mem[74], 32'h0000_000F);
        check("slt", mem[75], 32'd1);
        check("sltu", mem[76], 32'd0);
        check("sub", mem[77], 32'd9);
        check("add", mem[78], 32'h1234_4FF8);
        check("auipc", mem[79], 32'h0000_1070);
        check("sh_word", mem[80], 32'hFFF8_0000);
        check("lh_sext", mem[81], 32'hFFFF_FFF8);
        check("lhu_zext", mem[82], 32'h0000_FFF8);
        check("lw", mem[83], 32'd5);
        check("store_count", st_n, 32'd20);
        check("sb_addr", st_addr[1], 32'd3);
        check("sb_mode", {30'b0, st_mode[1]}, 32'd2);
        check("sb_data", {24'b0, st_data[1][7:0]}, 32'h0000_00FF);
        check("sh_mode", {30'b0, st_mode[16]}, 32'd1);
        check("sh_addr", st_addr[16], 32'h0000_0142);
        check("first_fetch", rd_addr[0], 32'd0);
        check("lb_mode", {30'b0, rd_mode[5]}, 32'd2);
        check("bne_target", rd_addr[14], 32'd52);
        check("jump_seq1", rd_addr[15], 32'd60);
        check("jump_seq2", rd_addr[16], 32'd56);
        check("jump_seq3", rd_addr[17], 32'd68);
        check("alu_latency", rd_cyc[1] - rd_cyc[0], 32'd3);
        check("store_latency", rd_cyc[2] - rd_cyc[1], 32'd4);
        check("load_req_delay", rd_cyc[5] - rd_cyc[4], 32'd2);
        check("load_latency", rd_cyc[6] - rd_cyc[4], 32'd4);

        snap_rd = rd_n;
        snap_st = st_n;
        repeat (40) @(negedge clk);
        check("halt_no_reads", rd_n, snap_rd);
        check("halt_no_stores", st_n, snap_st);
        check("halt_last_fetch", rd_addr[rd_n - 1], 32'd176);
        check("halt_valid_low", {31'b0, mem_addr_valid}, 32'd0);
`ifdef CRABCORE_DEBUG_EN
        check("halt_state", {28'b0, core_state_debug}, 32'd5);
        check("halt_pc", pc_debug, 32'd176);
        check("halt_x5", registers_debug[5], 32'd60);
        check("halt_x0", registers_debug[0], 32'd0);
`else
        check("dbg_reg_off", registers_debug[5], 32'd0);
`endif

        // Program B: reset during a stalled fetch, then a clean run from address 0.
        for (int i = 0; i < 256; i++) img[i] = '0;
        img[0] = enc_i(12'd5,   5'd0, 3'd0, 5'd1, OPC_IMM);
        img[1] = enc_s(12'h180, 5'd1, 5'd0, 3'd2);
        img[2] = ECALL;
        load_gen = 2;
        stall    = 1'b1;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("stall_valid", {31'b0, mem_addr_valid}, 32'd1);
        check("stall_addr", mem_addr, 32'd0);
        check("stall_io_mode", {30'b0, io_mode}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_valid", {31'b0, mem_addr_valid}, 32'd0);
`ifdef CRABCORE_DEBUG_EN
        check("abort_state", {28'b0, core_state_debug}, 32'd0);
`endif
        stall = 1'b0;
        base  = rd_n;
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("refetch_addr", rd_addr[base], 32'd0);
        check("refetch_reads", rd_n - base, 32'd3);
        check("refetch_store", mem[96], 32'd5);
        check("refetch_halt", {31'b0, mem_addr_valid}, 32'd0);
`ifdef CRABCORE_DEBUG_EN
        check("refetch_pc", pc_debug, 32'd8);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
